// File: rtl/seqgen_10010_tx.sv
// seqgen_10010_tx: serial pattern transmitter.
// On start, sends PATTERN (PLEN bits, MSB first) rep+1 times on aout/avalid,
// holds busy for the whole transmission and pulses done once at the end.
// Optional macro SEQGEN_GAP_EN inserts GAP idle cycles (busy still high)
// between consecutive copies; without it copies are sent back to back.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; done may be high for one cycle here
// ST_SEND | shifting pattern bits out, one per clk
// ST_GAP  | idle cycles between copies (only with SEQGEN_GAP_EN)
module seqgen_10010_tx #(
    parameter int              PLEN    = 5,
    parameter logic [PLEN-1:0] PATTERN = 5'b10010,
    parameter int              GAP     = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [3:0] rep,
    input  logic       abort,
    output logic       aout,
    output logic       avalid,
    output logic       busy,
    output logic       done
);

    localparam int            IW      = $clog2(PLEN);
    localparam logic [IW-1:0] IDX_MSB = IW'(PLEN - 1);

    // Out-of-range parameters would silently truncate the counters.
    if (PLEN < 2 || PLEN > 16) begin : g_bad_plen
        $error("seqgen_10010_tx: PLEN must be in 2..16");
    end
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("seqgen_10010_tx: GAP must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          aout_d, avalid_d, busy_d, done_d;
`ifdef SEQGEN_GAP_EN
    logic [3:0]    gap_q, gap_d;
`endif

    // State, datapath and registered outputs; reset aborts everything.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            aout    <= 1'b0;
            avalid  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SEQGEN_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            aout    <= aout_d;
            avalid  <= avalid_d;
            busy    <= busy_d;
            done    <= done_d;
`ifdef SEQGEN_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    // Next-state decision; abort always returns to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q == '0) begin
                    if (cnt_q == '0) state_d = ST_IDLE;
`ifdef SEQGEN_GAP_EN
                    else             state_d = ST_GAP;
`endif
                end
            end
            ST_GAP: begin
`ifdef SEQGEN_GAP_EN
                if (abort)               state_d = ST_IDLE;
                else if (gap_q == '0)    state_d = ST_SEND;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next output values and counters; aout is only ever set alongside avalid.
    always_comb begin
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        aout_d   = 1'b0;
        avalid_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SEQGEN_GAP_EN
        gap_d    = gap_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    idx_d    = IDX_MSB;
                    cnt_d    = rep;
                    aout_d   = PATTERN[IDX_MSB];
                    avalid_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_SEND: begin
                if (!abort) begin
                    if (idx_q != '0) begin
                        idx_d    = idx_q - 1'b1;
                        aout_d   = PATTERN[idx_q - 1'b1];
                        avalid_d = 1'b1;
                        busy_d   = 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_d  = cnt_q - 1'b1;
                        busy_d = 1'b1;
`ifdef SEQGEN_GAP_EN
                        gap_d    = 4'(GAP - 1);
`else
                        idx_d    = IDX_MSB;
                        aout_d   = PATTERN[IDX_MSB];
                        avalid_d = 1'b1;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
`ifdef SEQGEN_GAP_EN
                if (!abort) begin
                    busy_d = 1'b1;
                    if (gap_q != '0) begin
                        gap_d = gap_q - 1'b1;
                    end else begin
                        idx_d    = IDX_MSB;
                        aout_d   = PATTERN[IDX_MSB];
                        avalid_d = 1'b1;
                    end
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seqgen_10010_tx.sv
// Testbench for seqgen_10010_tx: table of transmission scenarios checked cycle
// by cycle through an expected-output queue, plus a hand-written async reset test.
module tb_seqgen_10010_tx;

    localparam int         PLEN = 5;
    localparam logic [4:0] PAT  = 5'b10010;
    localparam int         GAPP = 2;
`ifdef SEQGEN_GAP_EN
    localparam int         GAPC = GAPP;
`else
    localparam int         GAPC = 0;
`endif
    localparam int         T15  = 16 * PLEN + 15 * GAPC;
    localparam int         NEVER = 1 << 30;

    logic       clk, nrst, start, abort;
    logic [3:0] rep;
    logic       aout, avalid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];
    logic [4:0] pat_v;

    seqgen_10010_tx #(.PLEN(PLEN), .PATTERN(PAT), .GAP(GAPP)) dut (
        .clk(clk), .nrst(nrst), .start(start), .rep(rep), .abort(abort),
        .aout(aout), .avalid(avalid), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    rep1;
        int    ab;     // abort cycle, -1 = none
        int    s2;     // extra start cycle, -1 = none
        int    r2;
        int    s3;
        int    r3;
    } case_t;

    case_t cases[8];

    function automatic int tlen(int r);
        return (r + 1) * PLEN + r * GAPC;
    endfunction

    // Expected {aout,avalid,busy,done} in cycle k after a start at cycle 0,
    // observing nothing after cycle cut (abort).
    function automatic logic [3:0] tx_exp(int k, int r, int cut);
        int t, pos;
        t = tlen(r);
        if (k < 1 || k > cut) return 4'b0000;
        if (k <= t) begin
            pos = (k - 1) % (PLEN + GAPC);
            if (pos < PLEN) return {pat_v[PLEN-1-pos], 3'b110};
            return 4'b0010;
        end
        if (k == t + 1 && cut > t) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic check(string name, int cyc, logic [3:0] got, logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got {aout,avalid,busy,done}=%b expected %b",
                     name, cyc, got, exp);
        end
    endtask

    task automatic run_case(case_t tc);
        int  t1, cut1, free, last, t2, t3;
        bit  acc2, acc3;
        logic [3:0] e, got;
        t1   = tlen(tc.rep1);
        cut1 = (tc.ab >= 0 && tc.ab <= t1) ? tc.ab : NEVER;
        free = (cut1 != NEVER) ? cut1 + 1 : t1 + 1;
        t2   = tlen(tc.r2);
        t3   = tlen(tc.r3);
        acc2 = (tc.s2 >= 0) && (tc.s2 >= free);
        if (acc2) free = tc.s2 + t2 + 1;
        acc3 = (tc.s3 >= 0) && (tc.s3 >= free);
        last = t1 + 2;
        if (tc.s2 + 2 > last) last = tc.s2 + 2;
        if (tc.s3 + 2 > last) last = tc.s3 + 2;
        if (acc2 && tc.s2 + t2 + 2 > last) last = tc.s2 + t2 + 2;
        if (acc3 && tc.s3 + t3 + 2 > last) last = tc.s3 + t3 + 2;

        @(negedge clk);
        check({tc.name, " pre-idle"}, 0, {aout, avalid, busy, done}, 4'b0000);
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(negedge clk);
                got = {aout, avalid, busy, done};
                if (exp_q.size() == 0) begin
                    check({tc.name, " queue-empty"}, c, got, 4'bxxxx);
                end else begin
                    check(tc.name, c, got, exp_q.pop_front());
                end
            end
            start = (c == 0) || (c == tc.s2) || (c == tc.s3);
            rep   = (c == 0) ? 4'(tc.rep1) : (c == tc.s2) ? 4'(tc.r2) :
                    (c == tc.s3) ? 4'(tc.r3) : 4'($urandom_range(15));
            abort = (c == tc.ab);
            e = tx_exp(c + 1, tc.rep1, cut1);
            if (acc2) e = e | tx_exp(c + 1 - tc.s2, tc.r2, NEVER);
            if (acc3) e = e | tx_exp(c + 1 - tc.s3, tc.r3, NEVER);
            exp_q.push_back(e);
        end
        @(negedge clk);
        check(tc.name, last + 1, {aout, avalid, busy, done}, exp_q.pop_front());
        start = 1'b0;
        abort = 1'b0;
        rep   = 4'd0;
    endtask

    initial begin
        logic [3:0] e;
        pat_v = PAT;
        nrst  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        rep   = 4'd0;

        cases[0] = '{"rep0",          0, -1, -1, 0, -1, 0};
        cases[1] = '{"rep2",          2, -1, -1, 0, -1, 0};
        cases[2] = '{"abort_restart", 0,  3,  6, 0, -1, 0};
        cases[3] = '{"busy_start",    0, -1,  2, 7,  6, 0};
        cases[4] = '{"rep15_chain",  15, -1, 40, 3, T15 + 1, 1};
        cases[5] = '{"abort_wins",    0,  0,  3, 0, -1, 0};
        cases[6] = '{"abort_copy2",   1,  7, -1, 0, -1, 0};
        cases[7] = '{"rep3",          3, -1, -1, 0, -1, 0};

        // Reset state, including while start is presented.
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("reset_state", 0, {aout, avalid, busy, done}, 4'b0000);
        start = 1'b0;
        nrst  = 1'b1;

        foreach (cases[i]) run_case(cases[i]);

        // Asynchronous reset in the middle of a rep=3 transmission.
        @(negedge clk);
        start = 1'b1;
        rep   = 4'd3;
        @(negedge clk);
        start = 1'b0;
        rep   = 4'd0;
        repeat (3) @(negedge clk);
        e = tx_exp(4, 3, NEVER);
        check("mid_send", 4, {aout, avalid, busy, done}, e);
        @(posedge clk);
        #2 nrst = 1'b0;
        #1 check("async_reset", 5, {aout, avalid, busy, done}, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            check("no_resume", c, {aout, avalid, busy, done}, 4'b0000);
        end
        // A fresh start after reset transmits normally.
        start = 1'b1;
        rep   = 4'd0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            check("post_reset_tx", c, {aout, avalid, busy, done}, tx_exp(c, 0, NEVER));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
